// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP and the fetch FSM encoding.
// Latency: none, constants and types only.
// Backpressure: not applicable.
package rv32i_pkg;

  // Major opcodes (instr[6:0]), shared with the ALU decoder and main control
  localparam logic [6:0] LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_IMM = 7'b001_0011;
  localparam logic [6:0] AUIPC  = 7'b001_0111;
  localparam logic [6:0] STORE  = 7'b010_0011;
  localparam logic [6:0] OP     = 7'b011_0011;
  localparam logic [6:0] LUI    = 7'b011_0111;
  localparam logic [6:0] BRANCH = 7'b110_0011;
  localparam logic [6:0] JAL    = 7'b110_1111;
  localparam logic [6:0] JALR   = 7'b110_0111;

  // ADDI x0,x0,0 -- what the instruction register shows when it holds nothing
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  // Instruction addresses must be word aligned (no compressed extension)
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, downstream instruction, execute redirect.
// Latency: none, wiring only.
// Backpressure: imem_req_ready stalls requests, instr_ready stalls the held instruction.
interface instr_fetch_unit_if;
  import rv32i_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, opcode, funct3, funct7,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output fetch_fault
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, opcode, funct3, funct7,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  fetch_fault
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem request, instruction register, redirects.
// Latency: request handshake N, response M>=N+1, instr_valid at M+1; 3-cycle issue spacing best case.
// Backpressure: no new request while an instruction is held and instr_ready is low.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);
  import rv32i_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         discard_q, discard_d;
  logic         fetch_fault_q, fetch_fault_d;

  logic redir_ok;
  logic redir_bad;

  assign redir_ok  = bus.redirect_valid &&  is_word_aligned(bus.redirect_pc[1:0]);
  assign redir_bad = bus.redirect_valid && !is_word_aligned(bus.redirect_pc[1:0]);

  // Next-state: FSM transitions, PC update, instruction capture and squash
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    discard_d     = discard_q;
    fetch_fault_d = fetch_fault_q;

    case (state_q)
      S_REQ: begin
        if (redir_ok) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.imem_req_ready) begin
          // A redirect in the handshake cycle means the in-flight address is stale
          state_d   = S_WAIT;
          discard_d = redir_ok;
        end
      end
      S_WAIT: begin
        if (redir_ok) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_rsp_valid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          if (discard_q) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            instr_d    = bus.imem_rsp_data;
            instr_pc_d = pc_q;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Redirect wins over a simultaneous consume; the held word is wrong-path
        if (redir_ok) begin
          instr_d = NOP_INSTR;
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end else if (bus.instr_ready) begin
          instr_d = NOP_INSTR;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        // Terminal until reset
      end
    endcase

    // Misaligned target traps from any state; pc keeps the bad target for debug
    if (redir_bad) begin
      state_d       = S_FAULT;
      pc_d          = bus.redirect_pc;
      instr_d       = NOP_INSTR;
      discard_d     = 1'b0;
      fetch_fault_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      discard_q     <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      discard_q     <= discard_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ) && !rst;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = (state_q == S_HOLD);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.opcode         = instr_q[6:0];
  assign bus.funct3         = instr_q[14:12];
  assign bus.funct7         = instr_q[31:25];
  assign bus.fetch_fault    = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model.
// Latency: one step() per clock; outputs compared mid-cycle.
// Backpressure: bench drives imem_req_ready and instr_ready directly.
module tb_instr_fetch_unit;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Memory responder state
  int          mem_delay = 1;
  int          mem_cnt   = 0;
  logic [31:0] mem_paddr = 32'h0;
  logic [31:0] hs_addr[$];
  int          hs_cyc[$];
  int          cyc = 0;

  // Reference model: what the fetch unit owes the world
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_stale;
  logic        m_held;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h40B5_0533;
      32'h0000_000C: return 32'hDEAD_BEEF;
      default:       return {addr[24:0], 7'h13};
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    m_instr = NOP; m_ipc = RST_PC; m_fault = 1'b0;
  endtask

  task automatic model_update(input logic rv, input logic [31:0] rd);
    logic may_req;
    may_req = !m_busy && !m_held && !m_fault;
    if (rst) begin
      model_reset();
    end else if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) begin
      m_fault = 1'b1; m_pc = bus.redirect_pc; m_busy = 1'b0; m_held = 1'b0; m_stale = 1'b0;
    end else if (m_fault) begin
      // stuck until reset
    end else if (bus.redirect_valid) begin
      if (m_held) begin
        m_held = 1'b0;
      end else if (m_busy) begin
        if (rv) begin m_busy = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end else if (bus.imem_req_ready) begin
        m_busy = 1'b1; m_stale = 1'b1;
      end
      m_pc = bus.redirect_pc;
    end else if (m_held) begin
      if (bus.instr_ready) begin m_held = 1'b0; m_pc = m_pc + 32'd4; end
    end else if (m_busy) begin
      if (rv) begin
        m_busy = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else begin m_held = 1'b1; m_instr = rd; m_ipc = m_pc; end
      end
    end else if (may_req && bus.imem_req_ready) begin
      m_busy = 1'b1; m_stale = 1'b0;
    end
  endtask

  task automatic compare();
    logic        exp_req;
    logic [31:0] exp_instr;
    exp_req   = !rst && !m_busy && !m_held && !m_fault;
    exp_instr = m_held ? m_instr : NOP;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_held));
    chk("instr", bus.instr, exp_instr);
    chk("opcode", 32'(bus.opcode), 32'(exp_instr[6:0]));
    chk("funct3", 32'(bus.funct3), 32'(exp_instr[14:12]));
    chk("funct7", 32'(bus.funct7), 32'(exp_instr[31:25]));
    if (m_held) chk("instr_pc", bus.instr_pc, m_ipc);
    chk("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
  endtask

  // One clock: drive memory response, compare, advance model and memory at the edge
  task automatic step();
    logic        hs;
    logic        rv;
    logic [31:0] rd;
    logic [31:0] ra;
    rv = (mem_cnt == 1);
    rd = rv ? word_at(mem_paddr) : 32'h0;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    #1;
    compare();
    hs = bus.imem_req_valid && bus.imem_req_ready;
    ra = bus.imem_addr;
    @(posedge clk);
    model_update(rv, rd);
    if (mem_cnt > 0) mem_cnt--;
    if (hs) begin
      mem_cnt   = mem_delay;
      mem_paddr = ra;
      hs_addr.push_back(ra);
      hs_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(); step();

    // Reset state
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'h0);
    chk("rst_instr_pc", bus.instr_pc, RST_PC);

    // 1: straight-line fetch
    rst = 1'b0; #1;
    chk("rel_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    step(); step();
    chk("t1_valid", 32'(bus.instr_valid), 32'h1);
    chk("t1_instr", bus.instr, 32'h00A0_0093);
    chk("t1_opcode", 32'(bus.opcode), 32'h13);
    chk("t1_funct3", 32'(bus.funct3), 32'h0);
    chk("t1_funct7", 32'(bus.funct7), 32'h0);
    chk("t1_pc", bus.instr_pc, 32'h0);
    repeat (4) step();
    bus.instr_ready = 1'b0;
    step(); step();

    // 2: back-pressure on the word at 0x8
    chk("t2_instr", bus.instr, 32'h40B5_0533);
    chk("t2_funct7", 32'(bus.funct7), 32'h20);
    chk("t2_pc", bus.instr_pc, 32'h8);
    for (int i = 0; i < 5; i++) begin
      chk("t2_no_req", 32'(bus.imem_req_valid), 32'h0);
      chk("t2_hold_instr", bus.instr, 32'h40B5_0533);
      step();
    end
    bus.instr_ready = 1'b1;
    step();
    chk("t2_next_req", 32'(bus.imem_req_valid), 32'h1);
    chk("t2_next_addr", bus.imem_addr, 32'hC);
    chk("t1_hs_count", 32'(hs_addr.size()), 32'd3);
    if (hs_addr.size() >= 3) begin
      chk("t1_hs0", hs_addr[0], 32'h0);
      chk("t1_hs1", hs_addr[1], 32'h4);
      chk("t1_hs2", hs_addr[2], 32'h8);
      chk("t1_spacing01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      chk("t1_spacing12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end

    // 3: redirect while waiting; stale 0xDEADBEEF arrives two cycles later
    mem_delay = 3;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    step(); step();
    chk("t3_valid", 32'(bus.instr_valid), 32'h0);
    chk("t3_req", 32'(bus.imem_req_valid), 32'h1);
    chk("t3_addr", bus.imem_addr, 32'h100);
    mem_delay = 1;

    // 4: redirect in hold with simultaneous instr_ready
    step(); step();
    chk("t4_valid", 32'(bus.instr_valid), 32'h1);
    chk("t4_pc", bus.instr_pc, 32'h100);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_dropped", 32'(bus.instr_valid), 32'h0);
    chk("t4_nop", bus.instr, NOP);
    chk("t4_req", 32'(bus.imem_req_valid), 32'h1);
    chk("t4_addr", bus.imem_addr, 32'h200);

    // 5: misaligned redirect while a response is outstanding
    mem_delay = 3;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h302;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_fault", 32'(bus.fetch_fault), 32'h1);
    chk("t5_no_req", 32'(bus.imem_req_valid), 32'h0);
    repeat (3) step();
    chk("t5_fault_sticky", 32'(bus.fetch_fault), 32'h1);
    chk("t5_rsp_ignored", 32'(bus.instr_valid), 32'h0);
    chk("t5_still_no_req", 32'(bus.imem_req_valid), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("t5_fault_clr", 32'(bus.fetch_fault), 32'h0);
    chk("t5_restart_req", 32'(bus.imem_req_valid), 32'h1);
    chk("t5_restart_addr", bus.imem_addr, RST_PC);

    // 6: reset while waiting, late response right after release
    step();
    rst = 1'b1; mem_delay = 1;
    step(); step();
    rst = 1'b0; #1;
    chk("t6_req", 32'(bus.imem_req_valid), 32'h1);
    chk("t6_addr", bus.imem_addr, RST_PC);
    chk("t6_valid", 32'(bus.instr_valid), 32'h0);
    step(); step();
    chk("t6_refetch", bus.instr, 32'h00A0_0093);
    chk("t6_refetch_pc", bus.instr_pc, RST_PC);

    // Redirects in the request state, without and with handshake
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    chk("req_redir_addr", bus.imem_addr, 32'h40);
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80;
    step();
    bus.redirect_valid = 1'b0;
    repeat (5) step();
    chk("req_redir_stale", hs_addr[$-2], 32'h40);
    chk("req_redir_new", hs_addr[$-1], 32'h80);
    chk("req_redir_next", hs_addr[$], 32'h84);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
